// File: rtl/field_commit.sv
// field_commit: owns the playfield, merges a 4x4 piece one cell per cycle,
// then removes full rows bottom-up with gravity.
module field_commit #(
   parameter int COLS = 20,
   parameter int ROWS = 20
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   clear_field,
   input  logic [15:0]            block,
   input  logic [4:0]             block_pos_x,
   input  logic [4:0]             block_pos_y,
   output logic [ROWS*COLS-1:0]   field,
   output logic                   busy,
   output logic                   done,
   output logic [2:0]             lines_cleared,
   output logic                   overflow
);

   localparam int N  = ROWS * COLS;
   localparam int IW = $clog2(N);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MERGE,
      S_SCAN,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   field_q, field_d;
   logic [15:0]    blk_q, blk_d;
   logic [4:0]     px_q, px_d;
   logic [4:0]     py_q, py_d;
   logic [3:0]     cell_q, cell_d;
   logic [4:0]     row_q, row_d;
   logic [2:0]     lines_q, lines_d;
   logic           ovf_q, ovf_d;
   logic           done_q, done_d;
   logic           busy_q, busy_d;

   logic [5:0]     mx, my;
   logic [IW-1:0]  midx;
   logic           in_range;
   logic [ROWS-1:0] full;
   logic [N-1:0]   shifted;
   logic           cur_full, next_full;

   always_comb begin
      for (int r = 0; r < ROWS; r++) begin
         full[r] = &field_q[r*COLS +: COLS];
      end
   end

   assign cur_full  = full[row_q];
   // After a shift, the row under test holds what was directly above it.
   assign next_full = (row_q != 5'd0) && full[row_q - 5'd1];

   always_comb begin
      shifted = field_q;
      shifted[0 +: COLS] = '0;
      for (int r = 1; r < ROWS; r++) begin
         if (r <= int'(row_q)) begin
            shifted[r*COLS +: COLS] = field_q[(r-1)*COLS +: COLS];
         end
      end
   end

   assign mx       = {1'b0, px_q} + {4'b0, cell_q[1:0]};
   assign my       = {1'b0, py_q} + {4'b0, cell_q[3:2]};
   assign in_range = (mx < 6'(COLS)) && (my < 6'(ROWS));
   assign midx     = IW'(my) * IW'(COLS) + IW'(mx);

   always_comb begin
      state_d = state_q;
      field_d = field_q;
      blk_d   = blk_q;
      px_d    = px_q;
      py_d    = py_q;
      cell_d  = cell_q;
      row_d   = row_q;
      lines_d = lines_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               blk_d   = block;
               px_d    = block_pos_x;
               py_d    = block_pos_y;
               lines_d = 3'd0;
               ovf_d   = 1'b0;
               cell_d  = 4'd0;
               state_d = S_MERGE;
            end else if (clear_field) begin
               field_d = '0;
            end
         end
         S_MERGE: begin
            if (blk_q[cell_q]) begin
               if (in_range) begin
                  field_d[midx] = 1'b1;
               end else begin
                  ovf_d = 1'b1;
               end
            end
            if (cell_q == 4'd15) begin
               row_d   = 5'(ROWS - 1);
               state_d = S_SCAN;
            end else begin
               cell_d = cell_q + 4'd1;
            end
         end
         S_SCAN: begin
            if (cur_full) begin
               state_d = S_SHIFT;
            end else if (row_q == 5'd0) begin
               state_d = S_DONE;
            end else begin
               row_d = row_q - 5'd1;
            end
         end
         S_SHIFT: begin
            field_d = shifted;
            if (lines_q != 3'd7) begin
               lines_d = lines_q + 3'd1;
            end
            // The shifted-in row is judged here, saving a rescan cycle.
            if (next_full) begin
               state_d = S_SHIFT;
            end else if (row_q == 5'd0) begin
               state_d = S_DONE;
            end else begin
               row_d   = row_q - 5'd1;
               state_d = S_SCAN;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      done_d = (state_d == S_DONE);
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         field_q <= '0;
         blk_q   <= '0;
         px_q    <= '0;
         py_q    <= '0;
         cell_q  <= '0;
         row_q   <= '0;
         lines_q <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         field_q <= field_d;
         blk_q   <= blk_d;
         px_q    <= px_d;
         py_q    <= py_d;
         cell_q  <= cell_d;
         row_q   <= row_d;
         lines_q <= lines_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign field         = field_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign lines_cleared = lines_q;
   assign overflow      = ovf_q;

endmodule

// File: tb/tb_field_commit.sv
// tb_field_commit: random and directed commits checked against a
// row-list playfield model.
module tb_field_commit;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         clear_field;
   logic [15:0]  block;
   logic [4:0]   block_pos_x;
   logic [4:0]   block_pos_y;
   logic [399:0] field;
   logic         busy;
   logic         done;
   logic [2:0]   lines_cleared;
   logic         overflow;

   int n_chk;
   int n_err;
   logic [399:0] mfield;

   field_commit #(.COLS(20), .ROWS(20)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .clear_field   (clear_field),
      .block         (block),
      .block_pos_x   (block_pos_x),
      .block_pos_y   (block_pos_y),
      .field         (field),
      .busy          (busy),
      .done          (done),
      .lines_cleared (lines_cleared),
      .overflow      (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [399:0] got,
                      input logic [399:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drop the piece, then rebuild the field from the surviving rows
   // stacked against the floor.
   task automatic model_commit(input logic [15:0] b, input logic [4:0] px,
                               input logic [4:0] py, output int lines,
                               output bit ovf);
      logic [399:0] f;
      logic [19:0]  keep[$];
      logic [19:0]  rowv;
      int x, y;
      f = mfield;
      ovf = 1'b0;
      lines = 0;
      for (int i = 0; i < 16; i++) begin
         if (b[i]) begin
            x = int'(px) + i % 4;
            y = int'(py) + i / 4;
            if (x < 20 && y < 20) f[y*20 + x] = 1'b1;
            else ovf = 1'b1;
         end
      end
      for (int r = 19; r >= 0; r--) begin
         rowv = f[r*20 +: 20];
         if (&rowv) lines++;
         else keep.push_back(rowv);
      end
      f = '0;
      for (int k = 0; k < keep.size(); k++) begin
         f[(19-k)*20 +: 20] = keep[k];
      end
      mfield = f;
   endtask

   task automatic do_commit(input logic [15:0] b, input logic [4:0] px,
                            input logic [4:0] py, input bit hold,
                            input bit clr_busy);
      int lines;
      bit ov;
      int cyc;
      bit got;
      block       = b;
      block_pos_x = px;
      block_pos_y = py;
      start       = 1'b1;
      model_commit(b, px, py, lines, ov);
      @(posedge clk);
      #1;
      chk("busy_start", busy, 1);
      if (!hold) begin
         start       = 1'b0;
         block       = 16'($urandom);
         block_pos_x = 5'($urandom);
         block_pos_y = 5'($urandom);
      end
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
         if (done) begin
            got = 1'b1;
            clear_field = 1'b0;
         end else if (clr_busy) begin
            clear_field = 1'($urandom);
         end
      end
      clear_field = 1'b0;
      chk("latency", cyc, 36 + lines);
      chk("field", field, mfield);
      chk("lines", lines_cleared, lines);
      chk("overflow", overflow, ov);
      @(posedge clk);
      #1;
      chk("busy_idle", busy, 0);
      chk("done_low", done, 0);
   endtask

   initial begin
      logic [15:0] rb;
      logic [4:0]  rx, ry;
      n_chk = 0;
      n_err = 0;
      mfield = '0;
      rst_n = 1'b0;
      start = 1'b0;
      clear_field = 1'b0;
      block = '0;
      block_pos_x = '0;
      block_pos_y = '0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_field", field, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_lines", lines_cleared, 0);
      chk("rst_ovf", overflow, 0);
      @(negedge clk);
      rst_n = 1'b1;

      do_commit(16'h000F, 5'd0, 5'd19, 1'b0, 1'b0);
      chk("bar_bits", field[383:380], 4'hF);

      // Mid-merge reset must wipe everything without waiting for a clock.
      block = 16'hFFFF;
      block_pos_x = 5'd4;
      block_pos_y = 5'd4;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_field", field, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_lines", lines_cleared, 0);
      chk("mid_rst_ovf", overflow, 0);
      mfield = '0;
      @(negedge clk);
      rst_n = 1'b1;

      do_commit(16'h00FF, 5'd4, 5'd18, 1'b0, 1'b0);
      do_commit(16'h00FF, 5'd8, 5'd18, 1'b0, 1'b1);
      do_commit(16'h00FF, 5'd12, 5'd18, 1'b0, 1'b0);
      do_commit(16'h00FF, 5'd16, 5'd18, 1'b0, 1'b0);
      do_commit(16'h000C, 5'd0, 5'd18, 1'b0, 1'b0);
      do_commit(16'h0001, 5'd5, 5'd17, 1'b0, 1'b0);
      do_commit(16'h00F0, 5'd0, 5'd18, 1'b0, 1'b1);
      chk("lc_row19", field[399:380], 20'hFFFFC);
      chk("lc_row18", field[379:360], 20'h00020);
      chk("lc_row17", field[359:340], 20'h00000);

      @(negedge clk);
      clear_field = 1'b1;
      @(posedge clk);
      #1;
      clear_field = 1'b0;
      mfield = '0;
      chk("clear_idle", field, 0);

      do_commit(16'hFFFF, 5'd0, 5'd16, 1'b0, 1'b0);
      do_commit(16'hFFFF, 5'd4, 5'd16, 1'b0, 1'b0);
      do_commit(16'h1111, 5'd8, 5'd16, 1'b0, 1'b0);
      do_commit(16'hFFFF, 5'd10, 5'd16, 1'b0, 1'b0);
      do_commit(16'hFFFF, 5'd14, 5'd16, 1'b0, 1'b0);
      do_commit(16'h3333, 5'd18, 5'd16, 1'b0, 1'b0);
      do_commit(16'h2222, 5'd8, 5'd16, 1'b0, 1'b0);
      chk("four_empty", field, 0);
      chk("four_lines", lines_cleared, 4);

      do_commit(16'hFFFF, 5'd18, 5'd0, 1'b0, 1'b0);
      chk("oob_ovf", overflow, 1);
      chk("oob_r0", field[19:0], 20'hC0000);
      chk("oob_r3", field[79:60], 20'hC0000);
      do_commit(16'h0001, 5'd0, 5'd10, 1'b0, 1'b0);
      chk("oob_cleared", overflow, 0);
      do_commit(16'h8421, 5'd31, 5'd31, 1'b0, 1'b0);

      do_commit(16'h0033, 5'd7, 5'd9, 1'b1, 1'b1);
      do_commit(16'h0033, 5'd7, 5'd9, 1'b0, 1'b0);

      for (int i = 0; i < 20; i++) begin
         rb = 16'($urandom);
         rx = ($urandom_range(0, 7) == 0) ? 5'($urandom)
                                          : 5'($urandom_range(0, 19));
         ry = ($urandom_range(0, 7) == 0) ? 5'($urandom)
                                          : 5'($urandom_range(0, 19));
         do_commit(rb, rx, ry, (i != 19) && ($urandom_range(0, 3) == 0),
                   1'($urandom));
      end
      start = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
